uart_tx: RTL
============

# uart_tx

Serial UART transmitter: 8 data bits, LSB first, one start bit, one stop bit, and an optional parity bit. It serialises bytes from game logic (score reports, paddle/ball telemetry) onto a serial output pin toward the host. It is the transmit counterpart of the existing `rx_serial`/`rx_dv` receive path and runs in the same `clk_50` domain. With its defaults it interoperates with that receiver at 115200 baud.

## Interface
- `CLKS_PER_BIT`, default 434: `clk_50` cycles per serial bit (50 MHz / 115200). Legal range is 2..65535.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd. Other values are illegal; elaboration must fail.
- `clk_50`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_dv`  in  1  data-valid strobe. Accepted only in a cycle where `tx_ready`=1.
- `tx_byte`  in  8  byte to send. Sampled together with an accepted `tx_dv`.
- `tx_serial`  out  1  serial line. Idle level is 1.
- `tx_ready`  out  1  1 = block can accept a byte this cycle.
- `tx_active`  out  1  1 while a frame is on the line (start bit through stop bit).
- `tx_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- All outputs are registered.
- Reset values:
  - `tx_serial`=1, `tx_ready`=1, `tx_active`=0, `tx_done`=0.
  - State = IDLE; bit counter, baud counter and shift register = 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `tx_ready`=1, `tx_serial`=1.
  - On `tx_dv`=1: latch `tx_byte` into the shift register, compute the parity bit, go to START.
- START: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA
  - Drive the shift register LSB for `CLKS_PER_BIT` cycles, then shift right.
  - After bit 7: go to PARITY if `PARITY`!=0, else to STOP.
- PARITY
  - Drive the parity bit for `CLKS_PER_BIT` cycles.
  - Even: XOR of the 8 data bits. Odd: inverted XOR.
- STOP
  - Drive 1 for `CLKS_PER_BIT` cycles.
  - Then return to IDLE with `tx_done`=1 and `tx_ready`=1 for that cycle.
- Baud counter
  - Width is $clog2(`CLKS_PER_BIT`).
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on every bit boundary. Never free-running.
- Bit counter: 3 bits, counts 0..7 within DATA.
- `tx_active`=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- `tx_dv` while `tx_ready`=0 is ignored. No buffering, no error flag.
- Changes to `tx_byte` after acceptance do not affect the frame in flight.
- Reset mid-frame: the line returns to 1 immediately (asynchronously) and the frame is abandoned. `tx_done` is not asserted for it.

## Timing
- `tx_dv` sampled at edge N:
  - `tx_serial` falls after edge N.
  - `tx_active`=1 and `tx_ready`=0 are also set after edge N.
- Start bit occupies cycles N+1 .. N+`CLKS_PER_BIT`.
- Data bit k occupies cycles N+1+(k+1)·`CLKS_PER_BIT` onward, each lasting `CLKS_PER_BIT` cycles.
- Frame length F = 10·`CLKS_PER_BIT` cycles without parity, 11·`CLKS_PER_BIT` with parity.
- `tx_done`, `tx_ready`=1 and `tx_active`=0 are all set after edge N+F. The line stays 1.
- Back-to-back frames: a `tx_dv` sampled at edge N+F+1 (the `tx_done` cycle) starts the next start bit after that edge. The gap between stop bit and next start bit is one cycle.
- Throughput is one byte per F+1 cycles.
- Latency from accepted `tx_dv` to first line transition is 1 cycle.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle -> outputs go immediately to `tx_serial`=1, `tx_ready`=1, `tx_active`=0, `tx_done`=0, and hold through release.
- Byte 0x55, `CLKS_PER_BIT`=4, `PARITY`=0:
  - Line reads 0,1,0,1,0,1,0,1,0,1, each bit exactly 4 cycles.
  - `tx_done` pulses exactly once, 41 cycles after the `tx_dv` edge.
- `tx_dv` pulsed with 0xFF during a 0xA3 frame -> frame bits remain 0xA3 LSB-first; 0xFF is never transmitted; no extra `tx_done`.
- Back-to-back: hold `tx_dv`=1 with 0x01, then 0x80 presented in the `tx_done` cycle -> two correct frames, one idle-high cycle between them.
- Parity, `CLKS_PER_BIT`=4:
  - `PARITY`=1 with 0x07 -> parity bit 1, frame 44 cycles.
  - `PARITY`=2 with 0x07 -> parity bit 0.
- Reset during DATA bit 3 -> line 1 immediately; no `tx_done`; next accepted byte 0x3C transmits correctly from its start bit.

Source files
------------

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// All outputs are registered; reset returns the line to idle-high immediately.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       tx_dv,
    input  logic [7:0] tx_byte,
    output logic       tx_serial,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       tx_done
);

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be in 2..65535");
    end

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          serial_q, serial_d;
    logic          ready_q, ready_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_MAX);

    // Next-state, counters and datapath
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_dv) begin
                    shift_d = tx_byte;
                    par_d   = (PARITY == 2) ? ~(^tx_byte) : (^tx_byte);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        serial_d = 1'b1;
        unique case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = shift_d[0];
            S_PARITY: serial_d = par_d;
            default:  serial_d = 1'b1;
        endcase
        ready_d  = (state_d == S_IDLE);
        active_d = (state_d != S_IDLE);
        done_d   = (state_q == S_STOP) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign tx_serial = serial_q;
    assign tx_ready  = ready_q;
    assign tx_active = active_q;
    assign tx_done   = done_q;

endmodule
